stack_pop_assembler: RTL and testbench

Parametrised successor to the PC/flags restore accumulator in the memory stage. Collects a wide return value (PC, optionally preceded by a flags word) from consecutive narrow stack-pop beats on the data-memory read bus. Presents the assembled PC and restored flags to fetch and the flag register with single-cycle valid strobes. Used by RET/CALL-return (PC only) and RTI/interrupt-return (flags + PC).

---
 rtl/stack_pop_assembler_pkg.sv | 22 ++
 rtl/stack_pop_assembler.sv | 106 ++++++++++
 tb/tb_stack_pop_assembler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/stack_pop_assembler_pkg.sv
// Shared definitions for the stack-pop return path: FSM states, pop modes
// and the default bus/PC/flag widths used by the memory stage and SP unit.
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLAGS   = 2'd1,
    COLLECT = 2'd2
  } state_t;

  localparam logic MODE_POP_PC       = 1'b0;
  localparam logic MODE_POP_PC_FLAGS = 1'b1;

  localparam int unsigned DEF_BUS_W  = 16;
  localparam int unsigned DEF_OUT_W  = 32;
  localparam int unsigned DEF_FLAG_W = 3;

  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/stack_pop_assembler.sv
// Assembles a return PC (optionally preceded by a flags word) from narrow
// stack-pop beats, most-significant beat first, with single-cycle strobes.
module stack_pop_assembler
  import stack_pkg::*;
#(
  parameter int unsigned BUS_W  = DEF_BUS_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned FLAG_W = DEF_FLAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [BUS_W-1:0]  in_data,
  output logic              busy,
  output logic [OUT_W-1:0]  pc_out,
  output logic              pc_valid,
  output logic [FLAG_W-1:0] flags_out,
  output logic              flags_valid
);

  localparam int unsigned BEATS = OUT_W / BUS_W;
  localparam int unsigned CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [OUT_W-1:0]    r_shadow;
  logic [OUT_W-1:0]    r_pc;
  logic [FLAG_W-1:0]   r_flags;
  logic                r_pc_valid;
  logic                r_flags_valid;
  logic [OUT_W-1:0]    w_merged;

  // Shadow with the current beat dropped into its slot; constant slices only.
  always_comb begin
    w_merged = r_shadow;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_merged[OUT_W-1-k*BUS_W -: BUS_W] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_shadow      <= '0;
      r_pc          <= '0;
      r_flags       <= '0;
      r_pc_valid    <= 1'b0;
      r_flags_valid <= 1'b0;
    end else begin
      r_pc_valid    <= 1'b0;
      r_flags_valid <= 1'b0;
      if (abort) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_shadow <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_cnt    <= '0;
              r_shadow <= '0;
              r_state  <= (mode == MODE_POP_PC_FLAGS) ? FLAGS : COLLECT;
            end
          end
          FLAGS: begin
            if (in_valid) begin
              r_flags       <= in_data[FLAG_W-1:0];
              r_flags_valid <= 1'b1;
              r_cnt         <= '0;
              r_state       <= COLLECT;
            end
          end
          COLLECT: begin
            if (in_valid) begin
              if (r_cnt == LAST_BEAT) begin
                r_pc       <= w_merged;
                r_pc_valid <= 1'b1;
                r_shadow   <= '0;
                r_cnt      <= '0;
                r_state    <= IDLE;
              end else begin
                r_shadow <= w_merged;
                r_cnt    <= r_cnt + 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign pc_out      = r_pc;
  assign pc_valid    = r_pc_valid;
  assign flags_out   = r_flags;
  assign flags_valid = r_flags_valid;

endmodule

// File: tb/tb_stack_pop_assembler.sv
// Bench for stack_pop_assembler: directed scenarios plus random traffic
// against a beat-queue reference model, and two parameter variants.
module tb_stack_pop_assembler;

  localparam int unsigned BEATS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, mode = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        busy, pc_valid, flags_valid;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;

  logic        s48 = 1'b0, v48 = 1'b0;
  logic [15:0] d48 = '0;
  logic        busy48, pcv48, fv48;
  logic [47:0] pc48;
  logic [2:0]  fo48;

  logic        s16 = 1'b0, v16 = 1'b0;
  logic [15:0] d16 = '0;
  logic        busy16, pcv16, fv16;
  logic [15:0] pc16;
  logic [2:0]  fo16;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_busy = 1'b0, m_needf = 1'b0, m_pcv = 1'b0, m_fv = 1'b0;
  logic [31:0] m_pc = '0;
  logic [2:0]  m_flags = '0;
  logic [15:0] m_q[$];

  always #5 clk = ~clk;

  stack_pop_assembler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .busy(busy), .pc_out(pc_out),
    .pc_valid(pc_valid), .flags_out(flags_out), .flags_valid(flags_valid)
  );

  stack_pop_assembler #(.BUS_W(16), .OUT_W(48), .FLAG_W(3)) dut48 (
    .clk(clk), .rst_n(rst_n), .start(s48), .mode(1'b0), .abort(1'b0),
    .in_valid(v48), .in_data(d48), .busy(busy48), .pc_out(pc48),
    .pc_valid(pcv48), .flags_out(fo48), .flags_valid(fv48)
  );

  stack_pop_assembler #(.BUS_W(16), .OUT_W(16), .FLAG_W(3)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .mode(1'b0), .abort(1'b0),
    .in_valid(v16), .in_data(d16), .busy(busy16), .pc_out(pc16),
    .pc_valid(pcv16), .flags_out(fo16), .flags_valid(fv16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},        64'(busy),        64'(m_busy));
    chk({tag, ".pc_out"},      64'(pc_out),      64'(m_pc));
    chk({tag, ".pc_valid"},    64'(pc_valid),    64'(m_pcv));
    chk({tag, ".flags_out"},   64'(flags_out),   64'(m_flags));
    chk({tag, ".flags_valid"}, 64'(flags_valid), 64'(m_fv));
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_needf = 1'b0; m_pcv = 1'b0; m_fv = 1'b0;
    m_pc = '0; m_flags = '0; m_q.delete();
  endtask

  // One clock: apply inputs, predict what the edge does, then compare.
  task automatic cyc(input string tag, input logic s, input logic m,
                     input logic a, input logic v, input logic [15:0] d);
    logic [63:0] acc;
    start = s; mode = m; abort = a; in_valid = v; in_data = d;
    m_pcv = 1'b0; m_fv = 1'b0;
    if (a) begin
      m_busy = 1'b0; m_needf = 1'b0; m_q.delete();
    end else if (!m_busy) begin
      if (s) begin m_busy = 1'b1; m_needf = m; m_q.delete(); end
    end else if (v) begin
      if (m_needf) begin
        m_flags = d[2:0]; m_fv = 1'b1; m_needf = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == BEATS) begin
          acc = '0;
          foreach (m_q[i]) acc = (acc << 16) | 64'(m_q[i]);
          m_pc = acc[31:0]; m_pcv = 1'b1; m_busy = 1'b0; m_q.delete();
        end
      end
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    #1;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    #1 check_all("reset_held");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // POP_PC 0x0001, 0x2345
    cyc("pc_start", 1, 0, 0, 0, 16'h0);
    cyc("pc_b0",    0, 0, 0, 1, 16'h0001);
    cyc("pc_b1",    0, 0, 0, 1, 16'h2345);
    chk("pc_value", 64'(pc_out), 64'h0001_2345);
    cyc("pc_idle",  0, 0, 0, 0, 16'h0);

    // POP_PC with a 3-cycle gap
    cyc("gap_start", 1, 0, 0, 0, 16'h0);
    cyc("gap_b0",    0, 0, 0, 1, 16'h0001);
    for (int i = 0; i < 3; i++) cyc("gap_wait", 0, 0, 0, 0, 16'hDEAD);
    cyc("gap_b1",    0, 0, 0, 1, 16'h2345);

    // POP_PC_FLAGS
    cyc("fl_start", 1, 1, 0, 0, 16'h0);
    cyc("fl_b0",    0, 0, 0, 1, 16'hFFF5);
    chk("fl_value", 64'(flags_out), 64'h5);
    cyc("fl_b1",    0, 0, 0, 1, 16'h0000);
    cyc("fl_b2",    0, 0, 0, 1, 16'h0100);
    chk("fl_pc",    64'(pc_out), 64'h0000_0100);

    // abort together with the final beat, then a clean POP_PC
    cyc("ab_start", 1, 0, 0, 0, 16'h0);
    cyc("ab_b0",    0, 0, 0, 1, 16'h1234);
    cyc("ab_abort", 0, 0, 1, 1, 16'h5678);
    cyc("ab_st2",   1, 0, 1, 0, 16'h0);
    cyc("ab2_start", 1, 0, 0, 0, 16'h0);
    cyc("ab2_b0",   0, 0, 0, 1, 16'hAAAA);
    cyc("ab2_b1",   0, 0, 0, 1, 16'h5555);
    chk("ab2_pc",   64'(pc_out), 64'hAAAA_5555);

    // start while busy ignored; in_valid in IDLE ignored
    cyc("sb_start", 1, 1, 0, 0, 16'h0);
    cyc("sb_f",     1, 0, 0, 1, 16'h0003);
    cyc("sb_b0",    1, 1, 0, 1, 16'hCAFE);
    cyc("sb_b1",    1, 0, 0, 1, 16'hF00D);
    cyc("iv_idle0", 0, 0, 0, 1, 16'h7777);
    cyc("iv_idle1", 0, 0, 0, 1, 16'h8888);

    // asynchronous reset mid-sequence
    cyc("rs_start", 1, 0, 0, 0, 16'h0);
    cyc("rs_b0",    0, 0, 0, 1, 16'h4321);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all("rs_async");
    #2 rst_n = 1'b1;
    cyc("rs_after", 0, 0, 0, 1, 16'h9999);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom % 4) == 0, $urandom % 2, ($urandom % 16) == 0,
          ($urandom % 3) != 0, 16'($urandom));
    end
    cyc("rand_end", 0, 0, 1, 0, 16'h0);

    // OUT_W=48 variant
    s48 = 1'b1; @(posedge clk); #1 s48 = 1'b0;
    chk("w48_busy", 64'(busy48), 64'h1);
    v48 = 1'b1; d48 = 16'h1111; @(posedge clk); #1;
    d48 = 16'h2222; @(posedge clk); #1;
    chk("w48_nopv", 64'(pcv48), 64'h0);
    chk("w48_hold", 64'(pc48), 64'h0);
    d48 = 16'h3333; @(posedge clk); #1 v48 = 1'b0;
    chk("w48_pv",   64'(pcv48), 64'h1);
    chk("w48_pc",   64'(pc48), 64'h1111_2222_3333);
    chk("w48_idle", 64'(busy48), 64'h0);
    @(posedge clk); #1;
    chk("w48_pv_off", 64'(pcv48), 64'h0);
    chk("w48_fl", 64'({fv48, fo48}), 64'h0);

    // OUT_W=BUS_W=16 variant: pc_valid two cycles after start
    s16 = 1'b1; @(posedge clk); #1 s16 = 1'b0;
    chk("w16_nopv", 64'(pcv16), 64'h0);
    v16 = 1'b1; d16 = 16'hBEEF; @(posedge clk); #1 v16 = 1'b0;
    chk("w16_pv",   64'(pcv16), 64'h1);
    chk("w16_pc",   64'(pc16), 64'hBEEF);
    chk("w16_busy", 64'(busy16), 64'h0);
    chk("w16_fl",   64'({fv16, fo16}), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
